// File: rtl/seq_mult_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_unit_if
// Brief    : Handshake and operand/result bundle for seq_mult_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_mult_unit_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               ovf;
  logic               a_gt_b;

  modport master (output start, a, b, input busy, done, product, ovf, a_gt_b);
  modport slave  (input start, a, b, output busy, done, product, ovf, a_gt_b);
endinterface
`default_nettype wire

// File: rtl/seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_unit
// Brief    : Shift-add unsigned multiplier, start/busy/done handshake.
//            Optional SEQ_MULT_EARLY_EXIT_EN ends once remaining multiplier bits are zero.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_unit #(
  parameter int WIDTH = 8
) (
  input  wire              clk,
  input  wire              reset,
  seq_mult_unit_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] result;
  logic               ovf_flag;
  logic               gt_flag;
  logic               fsm_busy;
  logic               fsm_done;

  logic [WIDTH-1:0]   mplier_next;
  logic [CNT_W-1:0]   count_next;
  logic [2*WIDTH-1:0] acc_next;
  logic               accept;
  logic               finish;

  assign mplier_next = mplier >> 1;
  assign count_next  = count + CNT_W'(1);
  assign acc_next    = mplier[0] ? acc + mcand : acc;
  assign accept      = (state != S_BUSY) && bus.start;

`ifdef SEQ_MULT_EARLY_EXIT_EN
  assign finish = (state == S_BUSY) && ((count_next == LAST) || (mplier_next == '0));
`else
  assign finish = (state == S_BUSY) && (count_next == LAST);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = bus.start ? S_BUSY : S_IDLE;
      S_BUSY:  state_next = finish ? S_DONE : S_BUSY;
      S_DONE:  state_next = bus.start ? S_BUSY : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    fsm_busy = 1'b0;
    fsm_done = 1'b0;
    case (state)
      S_BUSY:  fsm_busy = 1'b1;
      S_DONE:  fsm_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load on acceptance, step while busy, publish on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      result   <= '0;
      ovf_flag <= 1'b0;
      gt_flag  <= 1'b0;
    end else if (accept) begin
      mcand    <= {{WIDTH{1'b0}}, bus.a};
      mplier   <= bus.b;
      acc      <= '0;
      count    <= '0;
      gt_flag  <= bus.a > bus.b;
    end else if (state == S_BUSY) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier_next;
      count  <= count_next;
      if (finish) begin
        result   <= acc_next;
        ovf_flag <= |acc_next[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign bus.busy    = fsm_busy;
  assign bus.done    = fsm_done;
  assign bus.product = result;
  assign bus.ovf     = ovf_flag;
  assign bus.a_gt_b  = gt_flag;
endmodule
`default_nettype wire

// File: tb/tb_seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_unit
// Brief    : Self-checking bench for seq_mult_unit with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_unit;
  localparam int W = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  seq_mult_unit_if #(.WIDTH(W)) bus ();

  seq_mult_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges a multiply takes for a given multiplier value.
  function automatic int lat(input logic [W-1:0] bv);
    int l;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < W; i++) if (bv[i]) l = i + 1;
`else
    l = W;
`endif
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: countdown of remaining edges plus pending result.
  int               m_left;
  bit               m_done;
  bit               m_valid;
  logic [2*W-1:0]   m_prod;
  logic [2*W-1:0]   m_pend;
  bit               m_ovf;
  bit               m_gt;

  initial begin
    m_left = 0; m_done = 0; m_valid = 0;
    m_prod = '0; m_pend = '0; m_ovf = 0; m_gt = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_done = 0; m_prod = '0; m_ovf = 0; m_gt = 0; m_valid = 1;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_done) begin
        m_prod = m_pend;
        m_ovf  = (m_pend >> W) != 0;
      end
    end else begin
      m_done = 0;
      if (bus.start) begin
        m_left = lat(bus.b);
        m_pend = (2*W)'(bus.a) * (2*W)'(bus.b);
        m_gt   = bus.a > bus.b;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",    32'(bus.busy),    32'(m_left > 0));
      chk("done",    32'(bus.done),    32'(m_done));
      chk("product", 32'(bus.product), 32'(m_prod));
      chk("ovf",     32'(bus.ovf),     32'(m_ovf));
      chk("a_gt_b",  32'(bus.a_gt_b),  32'(m_gt));
    end
  end

  // Called at a negedge with the unit idle or in its done cycle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, output int n);
    bus.start = 1'b1; bus.a = ta; bus.b = tb_v; n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
    end while (!bus.done && n < 40);
    if (n >= 40) chk("done_timeout", 32'(n), 32'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    int last_done;
    int pulses;
    checks = 0; errors = 0;
    reset = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    repeat (5) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_product", 32'(bus.product), 32'd0);
    end

    run_op(8'hFF, 8'hFF, n);
    chk("max_lat", 32'(n), 32'd9);
    chk("max_product", 32'(bus.product), 32'hFE01);
    chk("max_ovf", 32'(bus.ovf), 32'd1);
    chk("max_gt", 32'(bus.a_gt_b), 32'd0);

    run_op(8'hFF, 8'h00, n);
    chk("zero_lat", 32'(n), 32'(lat(8'h00) + 1));
    chk("zero_product", 32'(bus.product), 32'd0);
    chk("zero_ovf", 32'(bus.ovf), 32'd0);
    chk("zero_gt", 32'(bus.a_gt_b), 32'd1);

    run_op(8'd9, 8'd1, n);
    chk("b1_lat", 32'(n), 32'(lat(8'd1) + 1));
    chk("b1_product", 32'(bus.product), 32'd9);
    run_op(8'd9, 8'h80, n);
    chk("b80_lat", 32'(n), 32'd9);
    chk("b80_product", 32'(bus.product), 32'd1152);

    // Start held high: back-to-back results, start while busy ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd12; bus.b = 8'd10;
    last_done = -1; pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) begin
        chk("held_product", 32'(bus.product), 32'd120);
        chk("held_ovf", 32'(bus.ovf), 32'd0);
        chk("held_gt", 32'(bus.a_gt_b), 32'd1);
        if (last_done >= 0) chk("held_spacing", 32'(c - last_done), 32'(lat(8'd10) + 1));
        last_done = c;
        pulses++;
      end
    end
    chk("held_pulses_min", 32'(pulses >= 3), 32'd1);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in the 4th busy cycle aborts the operation.
    bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_product", 32'(bus.product), 32'd0);
    chk("abort_gt", 32'(bus.a_gt_b), 32'd0);
    run_op(8'd5, 8'd7, n);
    chk("after_abort_product", 32'(bus.product), 32'd35);

    // Random traffic, including starts while busy and rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset     = ($urandom % 250) == 0;
      bus.start = ($urandom % 4) == 0;
      bus.a     = pick();
      bus.b     = pick();
    end
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/seq_mult_unit.md
Name: seq_mult_unit

Overview:
- Parametrised, multi-cycle shift-add unsigned multiplier with a start/busy/done handshake.
- Successor to the fixed 3-bit combinational multiply/compare test block.
- Produces a 2*WIDTH product, an upper-half overflow flag and an a>b compare flag.
- Sits as a datapath helper for later multiply instructions (mult/multu stepping stone).

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product width is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only when not busy
- a  input  WIDTH  multiplicand, captured on the accepting edge
- b  input  WIDTH  multiplier, captured on the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: result outputs have just been updated
- product  output  2*WIDTH  registered a*b of the last completed operation
- ovf  output  1  registered; 1 when product[2*WIDTH-1:WIDTH] != 0
- a_gt_b  output  1  registered unsigned a>b of the captured operands

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE, busy=0, done=0, product=0, ovf=0, a_gt_b=0; internal accumulator, operand and counter registers=0.
- Reset has priority over every other input. Reset mid-operation aborts the operation with no done pulse; all outputs return to their reset values on that edge.
- States: IDLE, BUSY, DONE.
- IDLE, start=1: capture a into mcand (zero-extended to 2*WIDTH) and b into mplier; clear acc; count=0; a_gt_b <= (a>b); go to BUSY. start=0: stay in IDLE.
- BUSY, each edge:
  - if mplier[0], acc <= acc + mcand (2*WIDTH-bit add, no carry out possible);
  - mcand <= mcand<<1; mplier <= mplier>>1; count++.
  - On the edge where count reaches WIDTH: product <= final acc (including this edge's add); ovf computed from that value; done <= 1; go to DONE.
- DONE: lasts exactly one cycle with done=1. On the next edge done <= 0. start=1 on that edge is accepted as in IDLE (go BUSY); otherwise go to IDLE.
- busy is 1 exactly in BUSY. start in BUSY is ignored and not queued.
- Latency: done is high in the cycle that follows the WIDTH-th edge after the accepting edge. Back-to-back throughput is one result per WIDTH+1 cycles.
- product, ovf and a_gt_b are stable between done pulses. a_gt_b updates at acceptance, the others at completion.
- a and b may change freely after the accepting edge without affecting the result.
- Boundaries:
  - a=0 or b=0 gives product=0, ovf=0, with full latency.
  - Max operands (2^WIDTH-1)^2 give the product with no truncation.
  - a==b gives a_gt_b=0.

Optional Feature:
- Macro: SEQ_MULT_EARLY_EXIT_EN.
- Defined: in BUSY, if the shifted mplier value being written is zero, complete on that edge as if count had reached WIDTH (product/ovf/done/DONE identical). Latency becomes max(1, index of b's MSB set + 1) edges; b=0 completes after 1 BUSY edge.
- Not defined: fixed latency of WIDTH edges for every operand pair. Results are bit-identical in both builds.

Test Plan:
- Reset then idle -> all outputs 0, busy=0, for 5 cycles with start=0.
- WIDTH=3, a=3'b111, b=3'b000, start pulse -> busy for 3 cycles, done pulse, product=6'd0, ovf=0, a_gt_b=1.
- WIDTH=8, a=8'hFF, b=8'hFF -> done 8 edges after acceptance, product=16'hFE01, ovf=1, a_gt_b=0.
- WIDTH=8, a=8'd12, b=8'd10, start held high continuously -> results every 9 cycles, each product=16'd120, ovf=0, a_gt_b=1; start during busy has no effect.
- Start a=8'd200, b=8'd3, assert reset on the 4th BUSY cycle -> no done pulse, outputs 0; next start with a=5, b=7 gives product=35.
- With SEQ_MULT_EARLY_EXIT_EN: a=8'd9, b=8'd1 -> done after 1 BUSY edge, product=9; b=8'h80 -> 8 edges; without the macro both take 8 edges.
